// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and the
// clocks-per-bit derivation.
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  // Frame states. PARITY only exists when even-parity support is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

  // Number of system clocks per serial bit (integer divide).
  // The callers require the result to be at least 4.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// FIFO-side interface of the UART receive framer.
// master = framer (drives byte, strobe and status), slave = downstream FIFO.
// Optional feature macro: UART_RX_PARITY_EN adds the parity_err pulse.
interface uart_rx_framer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] dout;
  logic             wr_en;
  logic             full;
  logic             frame_err;
  logic             overrun;
  logic             busy;
`ifdef UART_RX_PARITY_EN
  logic             parity_err;
`endif

  modport master (
    input  full,
    output dout, wr_en, frame_err, overrun, busy
`ifdef UART_RX_PARITY_EN
    , output parity_err
`endif
  );

  modport slave (
    output full,
    input  dout, wr_en, frame_err, overrun, busy
`ifdef UART_RX_PARITY_EN
    , input parity_err
`endif
  );

endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// The reset value is a parameter so an idle-high line resets to 1 and a
// reset never manufactures a falling edge on the synchronized output.
module uart_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic stage_reg;
    if (gi == 0) begin : g_first
      // First stage captures the raw asynchronous input.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_reg <= RST_VAL;
        else        stage_reg <= d;
      end
    end else begin : g_chain
      // Later stages let any metastability settle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_reg <= RST_VAL;
        else        stage_reg <= g_stage[gi-1].stage_reg;
      end
    end
  end

  assign q = g_stage[STAGES-1].stage_reg;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: oversampled start/data/stop detection that writes each
// good byte into a downstream FIFO, with one-cycle error/overrun pulses.
// Frame: 1 start bit, WIDTH data bits LSB first, optional even parity, 1 stop.
// WIDTH must be at least 2; CLK_FREQ/BAUD_RATE must be at least 4.
// Optional feature macro: UART_RX_PARITY_EN enables even-parity checking.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  uart_rx_framer_if.master fifo
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int TW  = $clog2(CPB);
  localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Start bit is checked half a bit in; later bits a full bit after that,
  // so every later sample also lands mid-bit.
  localparam logic [TW-1:0] HALF_M1  = TW'(CPB / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(CPB - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  logic             rx_s;

  uart_state_t      state_reg,     state_next;
  logic [TW-1:0]    timer_reg,     timer_next;
  logic [IW-1:0]    index_reg,     index_next;
  logic [WIDTH-1:0] data_reg,      data_next;
  logic [WIDTH-1:0] dout_reg,      dout_next;
  logic             wr_en_reg,     wr_en_next;
  logic             frame_err_reg, frame_err_next;
  logic             overrun_reg,   overrun_next;
`ifdef UART_RX_PARITY_EN
  logic             parity_bit_reg, parity_bit_next;
  logic             parity_err_reg, parity_err_next;
  logic             parity_bad;
`endif

  uart_sync #(
    .STAGES  (2),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_bad = parity_bit_reg ^ (^data_reg);
`endif

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      timer_reg      <= '0;
      index_reg      <= '0;
      data_reg       <= '0;
      dout_reg       <= '0;
      wr_en_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      index_reg      <= index_next;
      data_reg       <= data_next;
      dout_reg       <= dout_next;
      wr_en_reg      <= wr_en_next;
      frame_err_reg  <= frame_err_next;
      overrun_reg    <= overrun_next;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= parity_bit_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  // Next-state and output decode; pulses default low, data holds.
  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg + TW'(1);
    index_next      = index_reg;
    data_next       = data_reg;
    dout_next       = dout_reg;
    wr_en_next      = 1'b0;
    frame_err_next  = 1'b0;
    overrun_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_next = parity_bit_reg;
    parity_err_next = 1'b0;
`endif

    case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        index_next = '0;
        if (!rx_s) state_next = ST_START;
      end

      ST_START: begin
        if (timer_reg == HALF_M1) begin
          timer_next = '0;
          index_next = '0;
          // A line that is high again by mid start bit was a glitch.
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (timer_reg == FULL_M1) begin
          timer_next = '0;
          data_next  = {rx_s, data_reg[WIDTH-1:1]};
          if (index_reg == LAST_IDX) begin
            index_next = '0;
`ifdef UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            index_next = index_reg + IW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (timer_reg == FULL_M1) begin
          timer_next      = '0;
          parity_bit_next = rx_s;
          state_next      = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (timer_reg == FULL_M1) begin
          // Leave right after the mid-stop sample so an immediately
          // following start bit is still seen from its leading edge.
          timer_next = '0;
          state_next = ST_IDLE;
          if (!rx_s) begin
            frame_err_next = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (parity_bad) begin
            parity_err_next = 1'b1;
`endif
          end else begin
            dout_next = data_reg;
            if (fifo.full) overrun_next = 1'b1;
            else           wr_en_next   = 1'b1;
          end
        end
      end

      default: begin
        timer_next = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign fifo.dout       = dout_reg;
  assign fifo.wr_en      = wr_en_reg;
  assign fifo.frame_err  = frame_err_reg;
  assign fifo.overrun    = overrun_reg;
  assign fifo.busy       = (state_reg != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign fifo.parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer (CLKS_PER_BIT = 16).
// Frames are serialised bit by bit; a frame-level model predicts which pulse
// each frame must produce and the byte on dout, and a compare process checks
// every output pulse against that prediction.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit and its checks.
module tb_uart_rx_framer;

  localparam int CPB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  always #5 clk = ~clk;

  uart_rx_framer_if #(.WIDTH(8)) fifo_if ();

  uart_rx_framer #(
    .CLK_FREQ  (1600000),
    .BAUD_RATE (100000),
    .WIDTH     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .fifo  (fifo_if)
  );

  logic perr_w;
`ifdef UART_RX_PARITY_EN
  assign perr_w = fifo_if.parity_err;
`else
  assign perr_w = 1'b0;
`endif

  typedef enum int {EV_WRITE = 0, EV_OVERRUN = 1, EV_FERR = 2, EV_PERR = 3} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] wr_log[$];
  logic [7:0] model_dout = 8'h00;

  int tests  = 0;
  int fails  = 0;
  int n_wr   = 0;
  int n_ovr  = 0;
  int n_ferr = 0;
  int n_perr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every output pulse must match the oldest predicted event.
  initial begin
    ev_t        e;
    logic [3:0] seen;
    logic [3:0] want;
    forever begin
      @(posedge clk);
      #1;
      seen = {perr_w, fifo_if.frame_err, fifo_if.overrun, fifo_if.wr_en};
      if (seen != 4'b0000) begin
        if (fifo_if.wr_en)     begin n_wr++; wr_log.push_back(fifo_if.dout); end
        if (fifo_if.overrun)   n_ovr++;
        if (fifo_if.frame_err) n_ferr++;
        if (perr_w)            n_perr++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {28'h0, seen}, 32'h0);
        end else begin
          e    = exp_q.pop_front();
          want = 4'b0001 << e.kind;
          chk("pulse_kind", {28'h0, seen}, {28'h0, want});
          chk("pulse_dout", {24'h0, fifo_if.dout}, {24'h0, e.data});
        end
      end
    end
  end

  // Watchdog: the run is a fixed number of bit times, so this only fires on a hang.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected end of run");
    $fatal(1, "[TB] timeout");
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Serialise one frame, predict its outcome, then confirm the pulse arrived
  // during the stop bit and dout holds the model's value.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                            input int gap);
    ev_t   e;
    string what;
    int    g;
    if (!stop_ok) begin
      e.kind = EV_FERR;    e.data = model_dout; what = "frame_err";
    end else if (!par_ok) begin
      e.kind = EV_PERR;    e.data = model_dout; what = "parity_err";
    end else begin
      model_dout = b;
      e.data     = b;
      if (fifo_if.full) begin e.kind = EV_OVERRUN; what = "overrun"; end
      else              begin e.kind = EV_WRITE;   what = "write";   end
    end
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ ~par_ok);
`endif
    drive_bit(stop_ok);
    chk("event_by_stop_end", exp_q.size(), 0);
    exp_q.delete();
    chk("dout_hold", {24'h0, fifo_if.dout}, {24'h0, model_dout});
    $display("[TB] frame 0x%02h stop=%0d par_ok=%0d full=%0d -> %s dout=0x%02h",
             b, stop_ok, par_ok, fifo_if.full, what, fifo_if.dout);
    rx = 1'b1;
    g  = (!stop_ok && gap < 2 * CPB) ? 2 * CPB : gap;
    repeat (g) @(negedge clk);
  endtask

  initial begin
    int         wr0, ferr0, ovr0, perr0;
    logic [7:0] rb;
    bit         rs, rp;
    int         rg;

    fifo_if.full = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state.
    chk("reset_dout",      {24'h0, fifo_if.dout}, 32'h0);
    chk("reset_wr_en",     {31'h0, fifo_if.wr_en}, 32'h0);
    chk("reset_frame_err", {31'h0, fifo_if.frame_err}, 32'h0);
    chk("reset_overrun",   {31'h0, fifo_if.overrun}, 32'h0);
    chk("reset_busy",      {31'h0, fifo_if.busy}, 32'h0);
    chk("reset_parity_err",{31'h0, perr_w}, 32'h0);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);

    // Single good frame.
    wr0 = n_wr; ferr0 = n_ferr; ovr0 = n_ovr;
    send_frame(8'h61, 1'b1, 1'b1, 2 * CPB);
    chk("r031_wr_count", n_wr - wr0, 1);
    chk("r031_dout", {24'h0, fifo_if.dout}, 32'h61);
    chk("r031_no_err", (n_ferr - ferr0) + (n_ovr - ovr0), 0);
    chk("r031_busy_after", {31'h0, fifo_if.busy}, 32'h0);

    // Back-to-back frames with no idle gap.
    wr0 = n_wr;
    send_frame(8'h41, 1'b1, 1'b1, 0);
    send_frame(8'h7A, 1'b1, 1'b1, 2 * CPB);
    chk("r032_wr_count", n_wr - wr0, 2);
    chk("r032_first",  {24'h0, wr_log[wr0]}, 32'h41);
    chk("r032_second", {24'h0, wr_log[wr0 + 1]}, 32'h7A);

    // Stop bit forced low.
    wr0 = n_wr; ferr0 = n_ferr;
    send_frame(8'h55, 1'b0, 1'b1, 3 * CPB);
    chk("r033_ferr_count", n_ferr - ferr0, 1);
    chk("r033_no_wr", n_wr - wr0, 0);
    chk("r033_dout_held", {24'h0, fifo_if.dout}, 32'h7A);

    // Start-bit glitch, then a real frame.
    wr0 = n_wr;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("r034_busy_in_start", {31'h0, fifo_if.busy}, 32'h1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("r034_busy_rejected", {31'h0, fifo_if.busy}, 32'h0);
    chk("r034_no_wr", n_wr - wr0, 0);
    send_frame(8'h30, 1'b1, 1'b1, 2 * CPB);
    chk("r034_dout", {24'h0, fifo_if.dout}, 32'h30);

    // Overrun, then reset in the middle of the next frame.
    wr0 = n_wr; ovr0 = n_ovr;
    fifo_if.full = 1'b1;
    send_frame(8'h42, 1'b1, 1'b1, 2 * CPB);
    chk("r035_ovr_count", n_ovr - ovr0, 1);
    chk("r035_no_wr", n_wr - wr0, 0);
    chk("r035_dout", {24'h0, fifo_if.dout}, 32'h42);
    fifo_if.full = 1'b0;
    wr0 = n_wr;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(rb_const(i));
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    model_dout = 8'h00;
    chk("r035_rst_dout",  {24'h0, fifo_if.dout}, 32'h0);
    chk("r035_rst_flags", {27'h0, fifo_if.wr_en, fifo_if.frame_err, fifo_if.overrun,
                           fifo_if.busy, perr_w}, 32'h0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10 * CPB) @(negedge clk);
    chk("r035_no_strobe", n_wr - wr0, 0);
    chk("r035_idle_after", {31'h0, fifo_if.busy}, 32'h0);

`ifdef UART_RX_PARITY_EN
    // Wrong parity, then correct parity.
    wr0 = n_wr; perr0 = n_perr;
    send_frame(8'h61, 1'b1, 1'b0, 2 * CPB);
    chk("r036_perr_count", n_perr - perr0, 1);
    chk("r036_no_wr", n_wr - wr0, 0);
    chk("r036_dout_held", {24'h0, fifo_if.dout}, 32'h0);
    send_frame(8'h61, 1'b1, 1'b1, 2 * CPB);
    chk("r036_wr_count", n_wr - wr0, 1);
    chk("r036_dout", {24'h0, fifo_if.dout}, 32'h61);
`else
    perr0 = n_perr;
`endif

    // Randomised frames: data, stop errors, parity errors, full, gaps.
    for (int k = 0; k < 40; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
      rp = ($urandom_range(0, 4) != 0);
`else
      rp = 1'b1;
`endif
      rg = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
      fifo_if.full = ($urandom_range(0, 3) == 0);
      send_frame(rb, rs, rp, rg);
    end
    fifo_if.full = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    chk("final_idle", {31'h0, fifo_if.busy}, 32'h0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Low bits of 0xA5, the frame interrupted by reset.
  function automatic logic rb_const(input int i);
    logic [7:0] v;
    v = 8'hA5;
    return v[i];
  endfunction

endmodule
